// File: rtl/arb_pkg.sv
// Shared types and default sizing for the hold-until-release round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int N_DEFAULT        = 8;
  localparam int MAX_HOLD_DEFAULT = 16;

endpackage

// File: rtl/rr_pri_chain.sv
// Rotating-priority one-hot selector: first set req at or after ptr, wrapping; purely combinational.
// The doubled request vector turns the wrap into a straight daisy chain.
module rr_pri_chain #(
  parameter int N  = 8,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [0:N-1]  req,
  input  logic [PW-1:0] ptr,
  output logic [0:N-1]  win
);

  logic [0:2*N-1] dbl_req;
  logic [0:2*N-1] hit;
  logic           taken;

  always_comb begin
    dbl_req = {req, req};
    hit     = '0;
    win     = '0;
    taken   = 1'b0;
    for (int i = 0; i < 2*N; i++) begin
      hit[i] = dbl_req[i] && (i >= int'(ptr)) && !taken;
      taken  = taken | hit[i];
    end
    for (int k = 0; k < N; k++) begin
      win[k] = hit[k] | hit[k+N];
    end
  end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter: registered one-hot grant 1 cycle after req, held until rel/req drop, one dead cycle after.
// No backpressure; optional forced release after MAX_HOLD busy cycles when ARB_TIMEOUT_EN is defined.
module rr_hold_arbiter
  import arb_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [0:N-1]         req,
  input  logic [0:N-1]         rel,
  output logic [0:N-1]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 timeout
);

  localparam int IW = $clog2(N);

  if (N < 2 || N > 32 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("rr_hold_arbiter: N must be 2..32 and MAX_HOLD >= 1");
  end

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [0:N-1]  grant_q, grant_d;
  logic [0:N-1]  win;
  logic [IW-1:0] win_id;
  logic          owner_rel;
  logic          hold_limit;

  rr_pri_chain #(.N(N), .PW(IW)) u_pri_chain (
    .req (req),
    .ptr (ptr_q),
    .win (win)
  );

  always_comb begin
    win_id = '0;
    for (int i = 0; i < N; i++) begin
      if (win[i]) win_id = IW'(i);
    end
  end

  // Only the owner's strobes matter; everyone else's rel is ignored.
  assign owner_rel = rel[id_q] | ~req[id_q];

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d;

  assign hold_limit = (hold_q == CW'(MAX_HOLD - 1));

  // A normal release on the limit edge wins, so no timeout pulse then.
  always_comb begin
    hold_d    = '0;
    timeout_d = 1'b0;
    if (state_q == BUSY && !owner_rel) begin
      if (hold_limit) timeout_d = 1'b1;
      else            hold_d    = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign hold_limit = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = win;
          id_d    = win_id;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (owner_rel || hold_limit) begin
          grant_d = '0;
          id_d    = '0;
          ptr_d   = (int'(id_q) == N - 1) ? '0 : id_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      grant_q <= grant_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = id_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed bench for rr_hold_arbiter (N=8, MAX_HOLD=16): vector table plus rotation and long-hold sequences.
module tb_rr_hold_arbiter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [0:N-1] req;
  logic [0:N-1] rel;
  logic [0:N-1] grant;
  logic         grant_valid;
  logic [2:0]   grant_id;
  logic         timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_hold_arbiter #(.N(N), .MAX_HOLD(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .rel         (rel),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout     (timeout)
  );

  typedef struct {
    logic         rst;
    logic [0:N-1] req;
    logic [0:N-1] rel;
    logic [0:N-1] g;
    logic [2:0]   id;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [0:N-1] q, input logic [0:N-1] l,
                     input logic [0:N-1] g, input logic [2:0] id);
    vec_t v;
    v.rst = r; v.req = q; v.rel = l; v.g = g; v.id = id;
    vecs.push_back(v);
  endtask

  function automatic logic [0:N-1] bit_of(input int k);
    logic [0:N-1] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, then sample 1 time unit later.
  task automatic step(input logic r, input logic [0:N-1] q, input logic [0:N-1] l);
    reset = r;
    req   = q;
    rel   = l;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [0:N-1] g, input logic [2:0] id,
                            input logic to);
    cmp({tag, " grant"},       32'(grant),       32'(g));
    cmp({tag, " grant_valid"}, 32'(grant_valid), 32'(|g));
    cmp({tag, " grant_id"},    32'(grant_id),    32'(id));
    cmp({tag, " timeout"},     32'(timeout),     32'(to));
    cmp({tag, " onehot"},      32'($countones(grant) <= 1), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    rel   = '0;

    // rst, req, rel, expected grant, expected id
    add(1'b1, 8'b11111111, 8'b00000000, 8'b00000000, 3'd0);
    add(1'b1, 8'b11111111, 8'b00000000, 8'b00000000, 3'd0);
    add(1'b0, 8'b11111111, 8'b00000000, 8'b10000000, 3'd0);
    add(1'b0, 8'b11111111, 8'b10000000, 8'b00000000, 3'd0);
    add(1'b1, 8'b00000000, 8'b00000000, 8'b00000000, 3'd0);
    add(1'b0, 8'b10100000, 8'b00000000, 8'b10000000, 3'd0);
    add(1'b0, 8'b10100000, 8'b00000000, 8'b10000000, 3'd0);
    add(1'b0, 8'b10100000, 8'b00010000, 8'b10000000, 3'd0);
    add(1'b0, 8'b10100000, 8'b10000000, 8'b00000000, 3'd0);
    add(1'b0, 8'b10100000, 8'b00000000, 8'b00100000, 3'd2);
    add(1'b0, 8'b10100000, 8'b00100000, 8'b00000000, 3'd0);
    add(1'b0, 8'b00000000, 8'b00000000, 8'b00000000, 3'd0);
    add(1'b0, 8'b00000000, 8'b11111111, 8'b00000000, 3'd0);
    add(1'b0, 8'b10000000, 8'b00000000, 8'b10000000, 3'd0);
    add(1'b0, 8'b10000000, 8'b10000000, 8'b00000000, 3'd0);
    add(1'b0, 8'b00000110, 8'b00000000, 8'b00000100, 3'd5);
    add(1'b0, 8'b00000110, 8'b00010000, 8'b00000100, 3'd5);
    add(1'b0, 8'b00000010, 8'b00000000, 8'b00000000, 3'd0);
    add(1'b0, 8'b00000010, 8'b00000000, 8'b00000010, 3'd6);
    add(1'b1, 8'b00000010, 8'b00000000, 8'b00000000, 3'd0);
    add(1'b0, 8'b00000011, 8'b00000000, 8'b00000010, 3'd6);
    add(1'b0, 8'b00000011, 8'b00000010, 8'b00000000, 3'd0);
    add(1'b0, 8'b00000011, 8'b00000000, 8'b00000001, 3'd7);
    add(1'b0, 8'b00000011, 8'b00000001, 8'b00000000, 3'd0);
    add(1'b0, 8'b00000011, 8'b00000000, 8'b00000010, 3'd6);
    add(1'b0, 8'b00000000, 8'b00000000, 8'b00000000, 3'd0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].rel);
      expect_out($sformatf("vec%0d", i), vecs[i].g, vecs[i].id, 1'b0);
    end

    // Full rotation: every owner releases one cycle after its grant.
    step(1'b1, 8'b11111111, 8'b00000000);
    expect_out("rot_reset", 8'b00000000, 3'd0, 1'b0);
    for (int k = 0; k <= N; k++) begin
      step(1'b0, 8'b11111111, 8'b00000000);
      expect_out($sformatf("rot_grant%0d", k), bit_of(k % N), 3'(k % N), 1'b0);
      step(1'b0, 8'b11111111, bit_of(k % N));
      expect_out($sformatf("rot_dead%0d", k), 8'b00000000, 3'd0, 1'b0);
    end

    // Owner 3 holds without releasing, requester 4 waiting.
    step(1'b1, 8'b00000000, 8'b00000000);
    expect_out("hold_reset", 8'b00000000, 3'd0, 1'b0);
    step(1'b0, 8'b00011000, 8'b00000000);
    expect_out("hold_c0", bit_of(3), 3'd3, 1'b0);
    for (int c = 1; c < 16; c++) begin
      step(1'b0, 8'b00011000, 8'b00000000);
      expect_out($sformatf("hold_c%0d", c), bit_of(3), 3'd3, 1'b0);
    end
`ifdef ARB_TIMEOUT_EN
    step(1'b0, 8'b00011000, 8'b00000000);
    expect_out("timeout_edge", 8'b00000000, 3'd0, 1'b1);
    step(1'b0, 8'b00011000, 8'b00000000);
    expect_out("after_timeout", bit_of(4), 3'd4, 1'b0);
    for (int c = 1; c < 16; c++) begin
      step(1'b0, 8'b00011000, 8'b00000000);
      expect_out($sformatf("hold4_c%0d", c), bit_of(4), 3'd4, 1'b0);
    end
    step(1'b0, 8'b00011000, bit_of(4));
    expect_out("rel_at_limit", 8'b00000000, 3'd0, 1'b0);
`else
    for (int c = 16; c < 56; c++) begin
      step(1'b0, 8'b00011000, 8'b00000000);
      expect_out($sformatf("hold_c%0d", c), bit_of(3), 3'd3, 1'b0);
    end
`endif

    // Reset while busy drops the grant without a timeout pulse.
    step(1'b1, 8'b00011000, 8'b00000000);
    expect_out("reset_busy", 8'b00000000, 3'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
